// File: rtl/rib_dma_pkg.sv
// Shared RIB definitions: bus widths, DMA state encoding and word-address helpers.
package rib_dma_pkg;

  localparam int RIB_ADDR_W = 32;
  localparam int RIB_DATA_W = 32;
  localparam int RIB_MASK_W = 4;
  localparam int RIB_WORD_W = RIB_ADDR_W - 2;

  localparam logic [RIB_MASK_W-1:0] RIB_MASK_FULL = 4'hF;
  localparam logic [RIB_MASK_W-1:0] RIB_MASK_NONE = 4'h0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD_REQ = 3'd1,
    ST_RD_RSP = 3'd2,
    ST_WR_REQ = 3'd3,
    ST_WR_RSP = 3'd4,
    ST_DONE   = 3'd5
  } dma_state_e;

  // Next word address; wraps silently from the top of the space to zero.
  function automatic logic [RIB_WORD_W-1:0] rib_next_word(input logic [RIB_WORD_W-1:0] w);
    return w + 30'd1;
  endfunction

  // Byte address of a word address (always word aligned).
  function automatic logic [RIB_ADDR_W-1:0] rib_word_to_addr(input logic [RIB_WORD_W-1:0] w);
    return {w, 2'b00};
  endfunction

endpackage

// File: rtl/rib_dma.sv
// Single-channel word copy engine on a RIB master port.
// One transaction outstanding at a time: read a word, write it, advance.
// All bus outputs are registered and decoded from the next state, so they
// change only on clock edges and drop to zero asynchronously on reset.
module rib_dma
  import rib_dma_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_start,
  input  logic [RIB_ADDR_W-1:0] i_src_addr,
  input  logic [RIB_ADDR_W-1:0] i_dst_addr,
  input  logic [LEN_W-1:0]      i_len,
  input  logic                  i_abort,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [RIB_ADDR_W-1:0] o_ribm_addr,
  output logic                  o_ribm_wrcs,
  output logic [RIB_MASK_W-1:0] o_ribm_mask,
  output logic [RIB_DATA_W-1:0] o_ribm_wdata,
  input  logic [RIB_DATA_W-1:0] i_ribm_rdata,
  output logic                  o_ribm_req,
  input  logic                  i_ribm_gnt,
  input  logic                  i_ribm_rsp,
  output logic                  o_ribm_rdy
);

  dma_state_e              state_q, state_d;
  logic [RIB_WORD_W-1:0]   src_q, src_d;
  logic [RIB_WORD_W-1:0]   dst_q, dst_d;
  logic [LEN_W-1:0]        len_q, len_d;
  logic [RIB_DATA_W-1:0]   data_q, data_d;

  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    req_q, req_d;
  logic                    rdy_q, rdy_d;
  logic                    wrcs_q, wrcs_d;
  logic [RIB_MASK_W-1:0]   mask_q, mask_d;
  logic [RIB_ADDR_W-1:0]   addr_q, addr_d;
  logic [RIB_DATA_W-1:0]   wdata_q, wdata_d;

  logic                    gnt_take_s;
  logic                    rsp_take_s;
  logic                    addr_lsb_unused_s;

  // Byte-offset bits of the addresses carry no meaning for word transfers.
  assign addr_lsb_unused_s = ^{i_src_addr[1:0], i_dst_addr[1:0]};

  // Handshakes only count when this side is actually asserting req/rdy.
  assign gnt_take_s = req_q & i_ribm_gnt;
  assign rsp_take_s = rdy_q & i_ribm_rsp;

  // Next-state and datapath update for the transfer sequencer.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    data_d  = data_q;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          src_d = i_src_addr[RIB_ADDR_W-1:2];
          dst_d = i_dst_addr[RIB_ADDR_W-1:2];
          len_d = i_len;
          if (i_len == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_RD_REQ;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RD_REQ: begin
        if (gnt_take_s) begin
          state_d = ST_RD_RSP;
        end else begin
          state_d = ST_RD_REQ;
        end
      end
      ST_RD_RSP: begin
        if (rsp_take_s) begin
          data_d  = i_ribm_rdata;
          state_d = ST_WR_REQ;
        end else begin
          state_d = ST_RD_RSP;
        end
      end
      ST_WR_REQ: begin
        if (gnt_take_s) begin
          state_d = ST_WR_RSP;
        end else begin
          state_d = ST_WR_REQ;
        end
      end
      ST_WR_RSP: begin
        if (rsp_take_s) begin
          src_d = rib_next_word(src_q);
          dst_d = rib_next_word(dst_q);
          len_d = len_q - LEN_W'(1);
          // Abort is only honoured here, once the word is fully written.
          if ((len_d == '0) || i_abort) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_RD_REQ;
          end
        end else begin
          state_d = ST_WR_RSP;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode from the next state so the registered outputs line up with the state.
  always_comb begin
    busy_d  = 1'b0;
    done_d  = 1'b0;
    req_d   = 1'b0;
    rdy_d   = 1'b0;
    wrcs_d  = 1'b0;
    mask_d  = RIB_MASK_NONE;
    addr_d  = '0;
    wdata_d = '0;
    case (state_d)
      ST_IDLE: begin
        busy_d = 1'b0;
      end
      ST_RD_REQ: begin
        busy_d = 1'b1;
        req_d  = 1'b1;
        mask_d = RIB_MASK_FULL;
        addr_d = rib_word_to_addr(src_d);
      end
      ST_RD_RSP: begin
        busy_d = 1'b1;
        rdy_d  = 1'b1;
      end
      ST_WR_REQ: begin
        busy_d  = 1'b1;
        req_d   = 1'b1;
        wrcs_d  = 1'b1;
        mask_d  = RIB_MASK_FULL;
        addr_d  = rib_word_to_addr(dst_d);
        wdata_d = data_d;
      end
      ST_WR_RSP: begin
        busy_d = 1'b1;
        rdy_d  = 1'b1;
      end
      ST_DONE: begin
        busy_d = 1'b1;
        done_d = 1'b1;
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  // State, datapath and output registers with asynchronous clear.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= ST_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      req_q   <= 1'b0;
      rdy_q   <= 1'b0;
      wrcs_q  <= 1'b0;
      mask_q  <= RIB_MASK_NONE;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      req_q   <= req_d;
      rdy_q   <= rdy_d;
      wrcs_q  <= wrcs_d;
      mask_q  <= mask_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign o_busy       = busy_q;
  assign o_done       = done_q;
  assign o_ribm_req   = req_q;
  assign o_ribm_rdy   = rdy_q;
  assign o_ribm_wrcs  = wrcs_q;
  assign o_ribm_mask  = mask_q;
  assign o_ribm_addr  = addr_q;
  assign o_ribm_wdata = wdata_q;

endmodule

// File: tb/tb_rib_dma.sv
// Scoreboard bench for rib_dma: a small RIB slave answers the DMA, every
// expected transaction is queued when a transfer is launched and popped
// when the DUT issues it.
module tb_rib_dma;

  localparam int LEN_W = 16;

  logic        clk;
  logic        rstn;
  logic        i_start;
  logic [31:0] i_src;
  logic [31:0] i_dst;
  logic [LEN_W-1:0] i_len;
  logic        i_abort;
  logic        o_busy;
  logic        o_done;
  logic [31:0] o_addr;
  logic        o_wrcs;
  logic [3:0]  o_mask;
  logic [31:0] o_wdata;
  logic [31:0] rdata;
  logic        o_req;
  logic        gnt;
  logic        rsp;
  logic        o_rdy;

  rib_dma #(.LEN_W(LEN_W)) dut (
    .i_clk        (clk),
    .i_rstn       (rstn),
    .i_start      (i_start),
    .i_src_addr   (i_src),
    .i_dst_addr   (i_dst),
    .i_len        (i_len),
    .i_abort      (i_abort),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_ribm_addr  (o_addr),
    .o_ribm_wrcs  (o_wrcs),
    .o_ribm_mask  (o_mask),
    .o_ribm_wdata (o_wdata),
    .i_ribm_rdata (rdata),
    .o_ribm_req   (o_req),
    .i_ribm_gnt   (gnt),
    .i_ribm_rsp   (rsp),
    .o_ribm_rdy   (o_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Slave read data is a fixed scramble of the address it was read from.
  function automatic logic [31:0] slv_data(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
  endfunction

  // Expected bus activity: kind 0 = read, 1 = write, 2 = done pulse.
  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  // Cycle counter.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Slave model: grant after gnt_wait cycles of req, respond the cycle after grant.
  int          gnt_wait = 0;
  int          wait_cnt;
  logic        rsp_noise = 1'b0;
  logic        pend;
  logic [31:0] last_addr;
  assign gnt   = (wait_cnt >= gnt_wait);
  assign rsp   = pend | rsp_noise;
  assign rdata = slv_data(last_addr);

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pend      <= 1'b0;
      wait_cnt  <= 0;
      last_addr <= 32'd0;
    end else begin
      if (pend && o_rdy) pend <= 1'b0;
      if (o_req && gnt) begin
        pend      <= 1'b1;
        wait_cnt  <= 0;
        last_addr <= o_addr;
      end else if (o_req) begin
        wait_cnt <= wait_cnt + 1;
      end
    end
  end

  // Monitor: pops the scoreboard on every handshake and done pulse, checks bus rules.
  int          done_cnt = 0;
  int          done_cyc = 0;
  int          busy_cnt = 0;
  int          rd_cnt   = 0;
  logic        prev_req = 1'b0;
  logic        prev_gnt = 1'b0;
  logic        prev_wrcs;
  logic [31:0] prev_addr;
  logic [31:0] prev_wdata;
  exp_t        mon_e;

  always @(negedge clk) begin
    if (rstn) begin
      if (o_req && gnt) begin
        check_val("txn_expected", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          check_val("txn_kind", 32'(o_wrcs), 32'(mon_e.kind));
          check_val("txn_addr", o_addr, mon_e.addr);
          if (mon_e.kind == 1) begin
            check_val("wr_data", o_wdata, mon_e.data);
            check_val("wr_mask", 32'(o_mask), 32'hF);
          end
        end
        if (!o_wrcs) rd_cnt++;
      end
      if (prev_req && !prev_gnt) begin
        check_val("hold_req", 32'(o_req), 32'd1);
        check_val("hold_addr", o_addr, prev_addr);
        check_val("hold_wrcs", 32'(o_wrcs), 32'(prev_wrcs));
        check_val("hold_wdata", o_wdata, prev_wdata);
      end
      if (!o_req) begin
        check_val("idle_addr", o_addr, 32'd0);
        check_val("idle_wdata", o_wdata, 32'd0);
      end
      if (o_req || o_rdy) check_val("req_rdy_excl", 32'(o_req & o_rdy), 32'd0);
      if (o_done) begin
        done_cnt++;
        done_cyc = cyc;
        check_val("done_expected", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          check_val("done_kind", 32'd2, 32'(mon_e.kind));
        end
      end
      if (o_busy) busy_cnt++;
      prev_req   = o_req;
      prev_gnt   = gnt;
      prev_wrcs  = o_wrcs;
      prev_addr  = o_addr;
      prev_wdata = o_wdata;
    end else begin
      prev_req = 1'b0;
    end
  end

  // Launch one transfer, queue its expected words, wait (bounded) for done.
  task automatic run_xfer(input logic [31:0] src, input logic [31:0] dst, input int len,
                          input int nwords, input int gwait, input logic noise,
                          input int abort_at, input int exp_lat, input logic poke_start);
    int t0;
    int d0;
    logic [31:0] a;
    gnt_wait  = gwait;
    rsp_noise = noise;
    for (int i = 0; i < nwords; i++) begin
      a = src + 32'(4 * i);
      sb.push_back('{0, a, 32'd0});
      sb.push_back('{1, dst + 32'(4 * i), slv_data(a)});
    end
    sb.push_back('{2, 32'd0, 32'd0});
    @(negedge clk);
    t0       = cyc;
    d0       = done_cnt;
    busy_cnt = 0;
    rd_cnt   = 0;
    i_start  = 1'b1;
    i_src    = src;
    i_dst    = dst;
    i_len    = LEN_W'(len);
    @(negedge clk);
    i_start = 1'b0;
    for (int c = 0; c < 3000 && done_cnt == d0; c++) begin
      @(negedge clk);
      if (abort_at > 0 && rd_cnt >= abort_at) i_abort = 1'b1;
      if (poke_start && c == 4) begin
        i_start = 1'b1;
        i_src   = 32'hDEAD_0000;
        i_dst   = 32'hBEEF_0000;
        i_len   = LEN_W'(7);
      end else begin
        i_start = 1'b0;
      end
    end
    check_val("done_seen", 32'(done_cnt != d0), 32'd1);
    repeat (3) @(negedge clk);
    i_abort   = 1'b0;
    i_start   = 1'b0;
    rsp_noise = 1'b0;
    check_val("done_once", 32'(done_cnt - d0), 32'd1);
    check_val("sb_drained", 32'(sb.size()), 32'd0);
    if (exp_lat >= 0) begin
      check_val("done_latency", 32'(done_cyc - t0), 32'(exp_lat));
      check_val("busy_cycles", 32'(busy_cnt), 32'(exp_lat));
    end
    sb.delete();
  endtask

  // Stimulus sequence.
  initial begin
    int d0;
    rstn    = 1'b1;
    i_start = 1'b0;
    i_src   = 32'd0;
    i_dst   = 32'd0;
    i_len   = '0;
    i_abort = 1'b0;
    #2 rstn = 1'b0;
    #1;
    check_val("rst_busy", 32'(o_busy), 32'd0);
    check_val("rst_done", 32'(o_done), 32'd0);
    check_val("rst_req", 32'(o_req), 32'd0);
    check_val("rst_rdy", 32'(o_rdy), 32'd0);
    check_val("rst_wrcs", 32'(o_wrcs), 32'd0);
    check_val("rst_mask", 32'(o_mask), 32'd0);
    check_val("rst_addr", o_addr, 32'd0);
    check_val("rst_wdata", o_wdata, 32'd0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // Ideal slave, three words: 4 cycles per word plus done.
    run_xfer(32'h0000_0100, 32'h0000_0200, 3, 3, 0, 1'b0, 0, 13, 1'b0);
    // Zero length: straight to done, busy for one cycle.
    run_xfer(32'h0000_0300, 32'h0000_0400, 0, 0, 0, 1'b0, 0, 1, 1'b0);
    // Grant withheld 5 cycles, with a stray start while busy.
    run_xfer(32'h1234_5678, 32'h8000_0010, 3, 3, 5, 1'b0, 0, -1, 1'b1);
    // Abort raised during the second read stops after two words.
    run_xfer(32'h0000_1000, 32'h0000_2000, 4, 2, 0, 1'b0, 2, -1, 1'b0);
    // Source address wraps to zero.
    run_xfer(32'hFFFF_FFFC, 32'h0000_5000, 2, 2, 0, 1'b0, 0, 9, 1'b0);
    // Response held high continuously, including grant cycles and idle.
    run_xfer(32'h0000_0A00, 32'h0000_0B00, 2, 2, 2, 1'b1, 0, -1, 1'b0);

    // Abort in idle has no lasting effect.
    i_abort = 1'b1;
    repeat (3) @(negedge clk);
    i_abort = 1'b0;
    run_xfer(32'h0000_0C00, 32'h0000_0D00, 2, 2, 0, 1'b0, 0, 9, 1'b0);

    // Reset while a write request is pending.
    gnt_wait = 3;
    sb.push_back('{0, 32'h0000_0E00, 32'd0});
    sb.push_back('{1, 32'h0000_0F00, slv_data(32'h0000_0E00)});
    @(negedge clk);
    i_start = 1'b1;
    i_src   = 32'h0000_0E00;
    i_dst   = 32'h0000_0F00;
    i_len   = LEN_W'(2);
    @(negedge clk);
    i_start = 1'b0;
    for (int c = 0; c < 200 && !(o_req && o_wrcs); c++) @(negedge clk);
    check_val("reach_wr_req", 32'(o_req && o_wrcs), 32'd1);
    d0   = done_cnt;
    rstn = 1'b0;
    #1;
    check_val("rst_mid_req", 32'(o_req), 32'd0);
    check_val("rst_mid_busy", 32'(o_busy), 32'd0);
    check_val("rst_mid_addr", o_addr, 32'd0);
    check_val("rst_mid_done", 32'(o_done), 32'd0);
    repeat (2) @(negedge clk);
    sb.delete();
    rstn = 1'b1;
    repeat (4) @(negedge clk);
    check_val("rst_no_done", 32'(done_cnt - d0), 32'd0);
    check_val("rst_idle_busy", 32'(o_busy), 32'd0);
    run_xfer(32'h0000_0E00, 32'h0000_0F00, 1, 1, 0, 1'b0, 0, 5, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
